// File: rtl/div_share_sched_pkg.sv
// Shared widths, FSM encoding and operand payload for the divider scheduler.
package div_sched_pkg;

  localparam int unsigned DV_W  = 22;
  localparam int unsigned DVN_W = 15;
  localparam int unsigned Q_W   = 22;

  localparam logic [Q_W-1:0] QUOT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [DV_W-1:0]  dv;
    logic [DVN_W-1:0] dvn;
  } op_t;

endpackage

// File: rtl/div_share_sched_if.sv
// Request/response bus between the statistics units (master) and the scheduler (slave).
interface div_share_sched_if
  import div_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) ();

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*DV_W-1:0]  req_dividend;
  logic [N_REQ*DVN_W-1:0] req_divisor;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [Q_W-1:0]         rsp_quot;
  logic [DV_W-1:0]        rsp_rem;
  logic                   rsp_div0;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_div0
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_div0
  );

endinterface

// File: rtl/div_share_sched_rr_arb.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping at N_REQ.
module rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt_c,
  output logic [IDW-1:0]   idx_c,
  output logic             any_c
);

  localparam logic [IDW:0] N_W = (IDW+1)'(N_REQ);

  logic [IDW:0]   pos;
  logic [IDW-1:0] cand;

  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = {1'b0, ptr} + (IDW+1)'(i);
      if (pos >= N_W) pos = pos - N_W;
      cand = pos[IDW-1:0];
      if (!any_c && req[cand]) begin
        any_c = 1'b1;
        idx_c = cand;
      end
    end
    gnt_c        = '0;
    gnt_c[idx_c] = any_c;
  end

endmodule

// File: rtl/div_share_sched.sv
// Shares one iterative fixed-point divider among N_REQ requesters with round-robin arbitration.
// Optional feature: DIVSCHED_DIV0_BYPASS_EN answers zero-divisor requests without using the divider.
module div_share_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DIV_CYCLES = 40,
  parameter int unsigned IDW        = 2
) (
  input  logic               clk,
  input  logic               rst,
  div_share_sched_if.slave   bus,
  output logic               div_load_n,
  output logic [DV_W-1:0]    div_dv,
  output logic [DVN_W-1:0]   div_dvn,
  input  logic [Q_W-1:0]     div_q,
  input  logic [DV_W-1:0]    div_r,
  output logic               busy
);

  localparam int unsigned      CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d, op_sel_c;
  logic [Q_W-1:0]   quot_q, quot_d;
  logic [DV_W-1:0]  rem_q, rem_d;
  logic             div0_q, div0_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             load_n_q, load_n_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] gnt_c, req_ready_c;
  logic [IDW-1:0]   gnt_idx_c;
  logic             gnt_any_c;

  rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .gnt_c (gnt_c),
    .idx_c (gnt_idx_c),
    .any_c (gnt_any_c)
  );

  // Operand mux for the granted requester
  always_comb begin
    op_sel_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_c[i]) begin
        op_sel_c.dv  = bus.req_dividend[DV_W*i +: DV_W];
        op_sel_c.dvn = bus.req_divisor[DVN_W*i +: DVN_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    div0_d      = div0_q;
    req_ready_c = '0;
    unique case (state_q)
      IDLE: begin
        // rst gate keeps the combinational accept silent while reset is held
        if (gnt_any_c && rst) begin
          req_ready_c = gnt_c;
          id_d        = gnt_idx_c;
          op_d        = op_sel_c;
          rr_ptr_d    = (gnt_idx_c == IDW'(N_REQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
          state_d     = LOAD;
`ifdef DIVSCHED_DIV0_BYPASS_EN
          if (op_sel_c.dvn == '0) begin
            state_d = DONE;
            quot_d  = QUOT_SAT;
            rem_d   = op_sel_c.dv;
            div0_d  = 1'b1;
          end
`endif
        end
      end
      LOAD: begin
        cnt_d   = CNT_INIT;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == '0) begin
          quot_d  = div_q;
          rem_d   = div_r;
          div0_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    load_n_d    = (state_d != LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      div0_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      load_n_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      div0_q      <= div0_d;
      rsp_valid_q <= rsp_valid_d;
      load_n_q    <= load_n_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_quot  = quot_q;
  assign bus.rsp_rem   = rem_q;
  assign bus.rsp_div0  = div0_q;
  assign div_load_n    = load_n_q;
  assign div_dv        = op_q.dv;
  assign div_dvn       = op_q.dvn;
  assign busy          = busy_q;

endmodule
